// File: rtl/pc_fetch_pkg.sv
// Shared widths, reset polarity, fetch FSM encoding and PC step helper.
package pc_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  // Reset is active-low: rst == RST_ENABLE_N means "in reset".
  localparam logic RST_ENABLE_N = 1'b0;

  localparam logic [INST_ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DROP = 2'b11
  } fetch_state_e;

  // Sequential successor; the addition wraps naturally at 2^32.
  function automatic logic [INST_ADDR_W-1:0] seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch front end.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one dead cycle after reset before the first request
// REQ   | request outstanding at pc; hand-off on ack unless IF/ID stalled
// HOLD  | word received while IF/ID stalled; buffered until release
// DROP  | flushed while a request was unacked; wait for ack, discard word
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  output logic                   ibus_req_o,
  output logic [INST_ADDR_W-1:0] ibus_addr_o,
  input  logic                   ibus_ack_i,
  input  logic [INST_W-1:0]      ibus_data_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_valid_o,
  output logic                   stallreq_o
);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic [INST_W-1:0]      buf_q, buf_d;
  logic [INST_ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic                   valid_q, valid_d;
  logic                   br_pend_q, br_pend_d;
  logic [INST_ADDR_W-1:0] br_tgt_q, br_tgt_d;

  logic                   handoff;
  logic [INST_W-1:0]      hand_inst;
  logic                   eff_br_pend;
  logic [INST_ADDR_W-1:0] eff_br_tgt;

  // Only the PC-freeze and IF/ID-freeze bits matter to fetch.
  logic unused_stall;
  assign unused_stall = ^stall[5:2];

  // A branch resolved this very cycle must steer the advance that ends the delay slot.
  assign eff_br_pend = br_pend_q | branch_flag_i;
  assign eff_br_tgt  = branch_flag_i ? branch_target_address_i : br_tgt_q;

  // Bus side: DROP keeps presenting the stale address so the bus transaction completes.
  assign ibus_req_o  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign ibus_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign stallreq_o  = ibus_req_o & ~ibus_ack_i;

  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  // Next-state, hand-off and next-PC selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_d       = buf_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    valid_d     = 1'b0;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    handoff     = 1'b0;
    hand_inst   = '0;

    if (branch_flag_i) begin
      br_pend_d = 1'b1;
      br_tgt_d  = branch_target_address_i;
    end

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (ibus_ack_i) begin
          if (!stall[1]) begin
            handoff   = 1'b1;
            hand_inst = ibus_data_i;
          end else begin
            buf_d   = ibus_data_i;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall[1]) begin
          handoff   = 1'b1;
          hand_inst = buf_q;
          state_d   = ST_REQ;
        end
      end
      ST_DROP: begin
        if (ibus_ack_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      // Redirect wins over stall and any pending branch; nothing is handed off.
      pc_d      = new_pc;
      br_pend_d = 1'b0;
      if (state_q == ST_REQ && !ibus_ack_i) begin
        drop_addr_d = pc_q;
        state_d     = ST_DROP;
      end else if (state_q == ST_DROP && !ibus_ack_i) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end else if (handoff) begin
      valid_d  = 1'b1;
      pc_out_d = pc_q;
      inst_d   = hand_inst;
      if (!stall[0]) begin
        pc_d      = eff_br_pend ? eff_br_tgt : seq_pc(pc_q);
        br_pend_d = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE_N) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_q       <= '0;
      pc_out_q    <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
      pc_out_q    <= pc_out_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then random traffic, hand-offs checked
// through a scoreboard queue filled by a transaction-level reference model.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i = 1'b0;
  logic [31:0] ibus_data_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus_req_o              (ibus_req_o),
    .ibus_addr_o             (ibus_addr_o),
    .ibus_ack_i              (ibus_ack_i),
    .ibus_data_i             (ibus_data_i),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .inst_valid_o            (inst_valid_o),
    .stallreq_o              (stallreq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } xfer_t;
  xfer_t sb_q[$];

  // Reference model: abstract fetch-engine view.
  logic [31:0] m_pc;
  bit          m_boot;       // dead cycle after reset pending
  bit          m_holding;    // a word has been captured and waits for IF/ID
  logic [31:0] m_held;
  bit          m_dropping;   // stale fetch still on the bus
  logic [31:0] m_stale;
  bit          m_br;
  logic [31:0] m_br_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_boot = 1; m_holding = 0; m_dropping = 0;
    m_held = '0; m_stale = '0; m_br = 0; m_br_tgt = '0;
    sb_q.delete();
  endtask

  task automatic deliver(input logic [31:0] w, input logic [5:0] st);
    xfer_t x;
    x.pc = m_pc; x.inst = w;
    sb_q.push_back(x);
    if (!st[0]) begin
      m_pc = m_br ? m_br_tgt : m_pc + 32'd4;
      m_br = 0;
    end
  endtask

  task automatic model_step(input bit ack, input logic [31:0] d, input logic [5:0] st,
                            input bit fl, input logic [31:0] npc, input bit br,
                            input logic [31:0] tgt);
    bool_fetching: begin end
    if (fl) begin
      if (!m_boot && !m_holding && !m_dropping && !ack) begin
        m_dropping = 1; m_stale = m_pc;
      end else if (m_dropping && ack) begin
        m_dropping = 0;
      end
      m_boot = 0; m_holding = 0; m_pc = npc; m_br = 0;
    end else begin
      if (br) begin m_br = 1; m_br_tgt = tgt; end
      if (m_boot) m_boot = 0;
      else if (m_dropping) begin if (ack) m_dropping = 0; end
      else if (m_holding) begin
        if (!st[1]) begin m_holding = 0; deliver(m_held, st); end
      end else if (ack) begin
        if (st[1]) begin m_holding = 1; m_held = d; end
        else deliver(d, st);
      end
    end
  endtask

  // One bus cycle; entered and left at posedge+1.
  task automatic cycle(input bit ack_in, input logic [5:0] st, input bit fl,
                       input logic [31:0] npc, input bit br, input logic [31:0] tgt);
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] d;
    bit          ack;
    exp_req  = !m_boot && !m_holding;
    exp_addr = m_dropping ? m_stale : m_pc;
    chk("ibus_req", {31'b0, ibus_req_o}, {31'b0, exp_req});
    if (exp_req) chk("ibus_addr", ibus_addr_o, exp_addr);
    ack = ack_in && exp_req;
    d   = ack ? word_at(exp_addr) : $urandom();
    ibus_ack_i = ack; ibus_data_i = d; stall = st; flush = fl; new_pc = npc;
    branch_flag_i = br; branch_target_address_i = tgt;
    #1;
    chk("stallreq", {31'b0, stallreq_o}, {31'b0, exp_req && !ack});
    model_step(ack, d, st, fl, npc, br, tgt);
    @(posedge clk); #1;
  endtask

  task automatic go(input bit ack);
    cycle(ack, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 0; ibus_ack_i = 0; stall = '0; flush = 0; branch_flag_i = 0;
    @(posedge clk); #1;
    chk("rst_req", {31'b0, ibus_req_o}, 32'h0);
    chk("rst_addr", ibus_addr_o, RESET_PC);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
    @(posedge clk); #1;
    model_reset();
    rst = 1;
  endtask

  // Monitor: every hand-off strobe must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst && inst_valid_o) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL handoff_unexpected: got pc %h inst %h expected none", pc_o, inst_o);
      end else begin
        xfer_t x;
        x = sb_q.pop_front();
        chk("handoff_pc", pc_o, x.pc);
        chk("handoff_inst", inst_o, x.inst);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Zero-wait streaming from reset: 0, 4, 8, C.
    go(1'b1);
    repeat (4) go(1'b1);
    chk("stream_next_addr", ibus_addr_o, 32'h10);

    // Ack delayed three cycles on 0x10.
    repeat (3) go(1'b0);
    go(1'b1);
    chk("after_wait_addr", ibus_addr_o, 32'h14);

    // Branch during fetch of 0x24: delay slot then 0x100.
    repeat (4) go(1'b1);
    chk("delay_slot_addr", ibus_addr_o, 32'h24);
    cycle(1'b1, 6'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("branch_target_addr", ibus_addr_o, 32'h100);

    // Branch into 0x80, then flush to 0x40 while 0x80 is unacked.
    cycle(1'b1, 6'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    cycle(1'b0, 6'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("drop_addr_hold", ibus_addr_o, 32'h80);
    go(1'b0);
    go(1'b1);
    chk("post_drop_addr", ibus_addr_o, 32'h40);

    // Redirect to 0x8, then IF/ID stall for four cycles after its ack.
    cycle(1'b0, 6'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    go(1'b1);
    cycle(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_req_low", {31'b0, ibus_req_o}, 32'h0);
    repeat (3) cycle(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    go(1'b0);
    chk("release_addr", ibus_addr_o, 32'hC);

    // Flush coincident with ack and branch: new_pc wins, then wrap to 0.
    cycle(1'b1, 6'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h200);
    chk("flush_wins_addr", ibus_addr_o, 32'hFFFF_FFFC);
    go(1'b1);
    chk("wrap_addr", ibus_addr_o, 32'h0);

    // Reset while a request is outstanding.
    go(1'b0);
    do_reset();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          a, f, b;
      logic [1:0]  sl;
      logic [5:0]  st;
      logic [31:0] np, tg;
      a  = ($urandom_range(0, 99) < 65);
      sl = ($urandom_range(0, 99) < 15) ? 2'b11 :
           (($urandom_range(0, 99) < 4) ? 2'($urandom_range(0, 3)) : 2'b00);
      st = {4'($urandom_range(0, 15)), sl};
      f  = ($urandom_range(0, 99) < 4);
      np = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      b  = ($urandom_range(0, 99) < 8);
      tg = $urandom() & 32'hFFFF_FFFC;
      cycle(a, st, f, np, b, tg);
      if (i == 1500) do_reset();
    end

    repeat (4) go(1'b1);
    @(negedge clk); #1;
    chk("scoreboard_empty", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
